stream_maxpool: RTL
===================

# stream_maxpool

Streaming 2x2, stride-2 max-pool stage for the CNN datapath. It accepts one signed feature-map pixel per handshake in raster order from the conv/ReLU stage and emits one pooled value per 2x2 window, also in raster order. It replaces the fixed four-input combinational maxpool with a line-buffered, back-pressurable, frame-aware block parametrised in data width and image size. It sits between the ReLU and the fully connected stages.

## Interface
- DATA_W, 16, pixel width; signed two's complement.
- IMG_W, 4, input columns; must be even and at least 2.
- IMG_H, 4, input rows; must be even and at least 2.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  input pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a pixel.
- out_data  out  DATA_W  pooled value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  out_data is the final pooled value of the frame.

## Operation
- Input accept: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- `in_ready = reset_deasserted && (!out_valid || out_ready)`. The block stalls the whole input while an un-taken output is pending.
- Position counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1.
  - Both advance only on accept.
  - col wraps to 0 and increments row.
  - After (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no gap.
- Even col: the pixel is held in the pair register `hold`.
- Odd col: `pmax = max(hold, in_data)`. All compares are signed.
  - Even row: `pmax` is written to line buffer entry col/2. The buffer has IMG_W/2 entries of DATA_W bits.
  - Odd row: `max(pmax, linebuf[col/2])` is loaded into out_data. out_valid is set to 1. out_last is set to 1 iff row == IMG_H-1 and col == IMG_W-1, and is cleared otherwise.
- out_data and out_last are held stable while `out_valid && !out_ready`.
- Output transfer with no new load: out_valid goes to 0 and out_last goes to 0.
- Output transfer and new load in the same cycle: the new value is loaded and out_valid stays 1.
- Pooled results per frame: (IMG_W/2)*(IMG_H/2).
- Arithmetic: compare only. There is no width growth, and out_data is DATA_W bits.

## Timing
- Reset values: out_data = 0, out_valid = 0, out_last = 0, in_ready = 0, col = 0, row = 0, hold = 0. Line buffer contents are don't-care and are not reset.
- Reset assertion mid-frame clears the partial frame immediately. The first accept after reset release is pixel (0,0) of a new frame.
- Latency: out_valid rises on the clock edge that accepts the bottom-right pixel of a window. This is 1 cycle after that pixel is presented with in_ready high.
- Throughput: 1 pixel per cycle when out_ready is held high.
- in_valid low: counters and state hold. No bubble is inserted into the frame geometry.

## Configuration
- Macro: MAXPOOL_RELU_EN.
- Defined: a fused ReLU is applied, so `out_data = (result < 0) ? 0 : result`. This lets the standalone ReLU stage be bypassed.
- Undefined: out_data is the raw signed maximum, and negative values pass through unchanged.
- Handshake and timing are identical in both builds.

## Test plan
- Basic pooling: IMG_W = 4, IMG_H = 4, input 1..16 in raster order, in_valid and out_ready held high.
  - Required outputs: 6, 8, 14, 16, in that order.
  - out_last = 1 on 16 only.
- Negative values: all 16 inputs = -5.
  - With MAXPOOL_RELU_EN: four outputs of 0.
  - Without it: four outputs of -5 (0xFFFB).
  - Mixed window {-3, -7, -1, -9}: -1 without the macro, 0 with it.
- Backpressure: out_ready = 0 from the start, with input 1..16.
  - in_ready drops the cycle after window 0 completes.
  - out_data holds 6 until out_ready rises.
  - Full sequence 6, 8, 14, 16 is still produced, with no loss or duplication.
- Back-to-back frames: 32 pixels, with the second frame = 17..32.
  - Required outputs: 6, 8, 14, 16, 22, 24, 30, 32.
  - out_last on 16 and on 32.
- Reset mid-frame: accept 6 pixels, pulse reset low for 1 cycle, then feed 1..16.
  - out_valid, out_data and out_last are 0 during reset.
  - Outputs after release: 6, 8, 14, 16.
- Max position and idle cycles: each 2x2 window has its maximum in a different quadrant, and in_valid is toggled randomly.
  - Each window's output equals its quadrant max.
  - Counters do not advance on idle cycles.

Source files
------------

// File: rtl/stream_maxpool.sv
// stream_maxpool: streaming 2x2 / stride-2 max-pool stage with a half-row
// line buffer, ready/valid handshakes on both sides and end-of-frame marking.
// Optional build macro: MAXPOOL_RELU_EN fuses a ReLU onto the pooled output.
module stream_maxpool #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int LB_N  = IMG_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] linebuf [LB_N];

    logic                     accept;
    logic [LB_AW-1:0]         lb_idx;
    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] pmax;
    logic signed [DATA_W-1:0] lb_rd;
    logic signed [DATA_W-1:0] wmax;
    logic signed [DATA_W-1:0] result;
    logic                     frame_end;

    // A pending un-taken output stalls the whole input side
    assign in_ready = reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign lb_idx   = LB_AW'(col >> 1);
    assign pix      = $signed(in_data);

    // Horizontal pair max, vertical window max and optional ReLU clamp
    always_comb begin
        pmax      = (pix > hold) ? pix : hold;
        lb_rd     = linebuf[lb_idx];
        wmax      = (pmax > lb_rd) ? pmax : lb_rd;
`ifdef MAXPOOL_RELU_EN
        result    = (wmax < 0) ? '0 : wmax;
`else
        result    = wmax;
`endif
        frame_end = (row == ROW_LAST) && (col == COL_LAST);
    end

    // Line buffer keeps the even-row pair maxima; contents need no reset
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_idx] <= pmax;
        end
    end

    // Position counters, pair register and registered output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    hold <= pix;
                end else if (row[0]) begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    out_last  <= frame_end;
                end
            end
        end
    end

endmodule
